// File: rtl/fetch_tgen_param.sv
// Instruction-fetch traffic generator: issues N_TRANS requests, tracks
// outstanding grants, folds responses into a checksum, and flags protocol errors.
module fetch_tgen_param #(
  parameter int unsigned FETCH_ADDR_WIDTH = 32,
  parameter int unsigned FETCH_DATA_WIDTH = 128,
  parameter int unsigned N_TRANS          = 1024,
  parameter int unsigned MAX_OUTSTANDING  = 4,
  parameter logic [31:0] ADDR_MASK        = 32'h0000_0FFF,
  parameter logic [31:0] LFSR_SEED        = 32'hACE1_2468
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        fetch_enable_i,
  input  logic [1:0]                  mode_i,
  output logic                        fetch_req_o,
  output logic [FETCH_ADDR_WIDTH-1:0] fetch_addr_o,
  input  logic                        fetch_gnt_i,
  input  logic                        fetch_rvalid_i,
  input  logic [FETCH_DATA_WIDTH-1:0] fetch_rdata_i,
  output logic                        eoc_o,
  output logic                        err_o,
  output logic [FETCH_DATA_WIDTH-1:0] rdata_chk_o,
  output logic [23:0]                 resp_cnt_o
);

  localparam int unsigned AW     = FETCH_ADDR_WIDTH;
  localparam int unsigned DW     = FETCH_DATA_WIDTH;
  localparam int unsigned BYTES  = DW / 8;
  localparam int unsigned CNT_W  = 24;
  localparam int unsigned OUTS_W = 4;
  localparam int unsigned GAP_W  = 2;

  localparam logic [31:0]       SEED      = (LFSR_SEED == 32'h0) ? 32'h1 : LFSR_SEED;
  localparam logic [31:0]       LFSR_TAPS = 32'h8020_0003;
  localparam logic [AW-1:0]     MASK_W    = AW'(ADDR_MASK);
  localparam logic [AW-1:0]     ALIGN_W   = ~AW'(BYTES - 1);
  localparam logic [AW-1:0]     STEP_W    = AW'(BYTES);
  localparam logic [CNT_W-1:0]  N_TRANS_W = CNT_W'(N_TRANS);
  localparam logic [CNT_W-1:0]  LAST_IDX  = CNT_W'(N_TRANS - 1);
  localparam logic [OUTS_W-1:0] MAX_OUTS  = OUTS_W'(MAX_OUTSTANDING);

  localparam logic [1:0] MODE_SEQ = 2'd1;
  localparam logic [1:0] MODE_GAP = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic                req_q, req_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic [AW-1:0]       seq_q, seq_d;
  logic [OUTS_W-1:0]   outs_q, outs_d;
  logic [CNT_W-1:0]    issued_q, issued_d;
  logic [31:0]         lfsr_q, lfsr_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [1:0]          mode_q, mode_d;
  logic                eoc_q, eoc_d;
  logic                err_q, err_d;
  logic [DW-1:0]       chk_q, chk_d;
  logic [CNT_W-1:0]    resp_q, resp_d;

  logic accept;
  logic rvalid_ok;
  logic issue_ok;

  // Galois step for x^32+x^22+x^2+x+1 (right-shifting form)
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

  assign accept    = req_q & fetch_gnt_i;
  assign rvalid_ok = fetch_rvalid_i & (outs_q != '0);

  // State register and all registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      req_q    <= 1'b0;
      addr_q   <= '0;
      seq_q    <= '0;
      outs_q   <= '0;
      issued_q <= '0;
      lfsr_q   <= SEED;
      gap_q    <= '0;
      mode_q   <= '0;
      eoc_q    <= 1'b0;
      err_q    <= 1'b0;
      chk_q    <= '0;
      resp_q   <= '0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      addr_q   <= addr_d;
      seq_q    <= seq_d;
      outs_q   <= outs_d;
      issued_q <= issued_d;
      lfsr_q   <= lfsr_d;
      gap_q    <= gap_d;
      mode_q   <= mode_d;
      eoc_q    <= eoc_d;
      err_q    <= err_d;
      chk_q    <= chk_d;
      resp_q   <= resp_d;
    end
  end

  // Next-state, counters and request generation
  always_comb begin
    state_d  = state_q;
    req_d    = 1'b0;
    addr_d   = addr_q;
    seq_d    = seq_q;
    outs_d   = outs_q;
    issued_d = issued_q;
    lfsr_d   = lfsr_q;
    gap_d    = gap_q;
    mode_d   = mode_q;
    err_d    = err_q;
    chk_d    = chk_q;
    resp_d   = resp_q;
    eoc_d    = 1'b0;
    issue_ok = 1'b0;

    if (state_q == ST_IDLE) begin
      mode_d = mode_i;
    end

    // Gap reload uses the LFSR value that produced the accepted address
    if (accept) begin
      issued_d = issued_q + CNT_W'(1);
      lfsr_d   = lfsr_step(lfsr_q);
      seq_d    = (seq_q + STEP_W) & MASK_W;
      gap_d    = (mode_q == MODE_GAP) ? lfsr_q[GAP_W-1:0] : '0;
    end else if (gap_q != '0) begin
      gap_d = gap_q - GAP_W'(1);
    end

    case ({accept, rvalid_ok})
      2'b10:   outs_d = outs_q + OUTS_W'(1);
      2'b01:   outs_d = outs_q - OUTS_W'(1);
      default: outs_d = outs_q;
    endcase

    if (fetch_rvalid_i) begin
      chk_d  = chk_q ^ fetch_rdata_i;
      resp_d = resp_q + CNT_W'(1);
    end

    // A response with nothing previously granted cannot belong to anything
    if ((fetch_rvalid_i && (outs_q == '0)) || (fetch_gnt_i && !req_q)) begin
      err_d = 1'b1;
    end

    case (state_q)
      ST_IDLE:  if (fetch_enable_i) state_d = ST_RUN;
      ST_RUN:   if (accept && (issued_q == LAST_IDX)) state_d = ST_DRAIN;
      ST_DRAIN: if (outs_q == '0) state_d = ST_DONE;
      ST_DONE:  state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase

    issue_ok = (state_d == ST_RUN) && fetch_enable_i && (issued_d < N_TRANS_W) &&
               (outs_d < MAX_OUTS) && (gap_d == '0);

    // A pending request keeps its address until granted
    if (req_q && !fetch_gnt_i) begin
      req_d = 1'b1;
    end else if (issue_ok) begin
      req_d  = 1'b1;
      addr_d = (mode_d == MODE_SEQ) ? (seq_d & ALIGN_W)
                                    : (AW'(lfsr_d) & MASK_W & ALIGN_W);
    end

    eoc_d = (state_d == ST_DONE);
  end

  assign fetch_req_o  = req_q;
  assign fetch_addr_o = addr_q;
  assign eoc_o        = eoc_q;
  assign err_o        = err_q;
  assign rdata_chk_o  = chk_q;
  assign resp_cnt_o   = resp_q;

endmodule

// File: tb/tb_fetch_tgen_param.sv
// Bench for fetch_tgen_param: two configurations driven with directed and
// randomized traffic, checked against a queue-based reference model.
`timescale 1ns/1ps
module tb_fetch_tgen_param;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         en        [2];
  logic [1:0]   mode      [2];
  logic         gnt_en    [2];
  logic         gnt_force [2];
  logic         rv        [2];
  logic [127:0] rd        [2];

  logic         req_a, req_b, gnt_a, gnt_b, eoc_a, eoc_b, err_a, err_b;
  logic [31:0]  addr_a, addr_b;
  logic [127:0] chk_a;
  logic [63:0]  chk_b;
  logic [23:0]  resp_a, resp_b;

  int n_cmp  = 0;
  int n_fail = 0;

  assign gnt_a = (req_a & gnt_en[0]) | gnt_force[0];
  assign gnt_b = (req_b & gnt_en[1]) | gnt_force[1];

  fetch_tgen_param #(
    .FETCH_ADDR_WIDTH(32), .FETCH_DATA_WIDTH(128), .N_TRANS(8),
    .MAX_OUTSTANDING(4), .ADDR_MASK(32'h0000_0FFF), .LFSR_SEED(32'hACE1_2468)
  ) u_a (
    .clk(clk), .rst(rst), .fetch_enable_i(en[0]), .mode_i(mode[0]),
    .fetch_req_o(req_a), .fetch_addr_o(addr_a), .fetch_gnt_i(gnt_a),
    .fetch_rvalid_i(rv[0]), .fetch_rdata_i(rd[0]), .eoc_o(eoc_a), .err_o(err_a),
    .rdata_chk_o(chk_a), .resp_cnt_o(resp_a)
  );

  fetch_tgen_param #(
    .FETCH_ADDR_WIDTH(32), .FETCH_DATA_WIDTH(64), .N_TRANS(10),
    .MAX_OUTSTANDING(2), .ADDR_MASK(32'h0000_003F), .LFSR_SEED(32'h0000_0001)
  ) u_b (
    .clk(clk), .rst(rst), .fetch_enable_i(en[1]), .mode_i(mode[1]),
    .fetch_req_o(req_b), .fetch_addr_o(addr_b), .fetch_gnt_i(gnt_b),
    .fetch_rvalid_i(rv[1]), .fetch_rdata_i(rd[1][63:0]), .eoc_o(eoc_b), .err_o(err_b),
    .rdata_chk_o(chk_b), .resp_cnt_o(resp_b)
  );

  // Per-instance configuration, mirroring the parameter overrides above
  function automatic int cfg_n(input int i);       return (i == 0) ? 8 : 10;               endfunction
  function automatic int cfg_bytes(input int i);   return (i == 0) ? 16 : 8;               endfunction
  function automatic int cfg_max(input int i);     return (i == 0) ? 4 : 2;                endfunction
  function automatic logic [31:0] cfg_mask(input int i); return (i == 0) ? 32'hFFF : 32'h3F; endfunction
  function automatic logic [31:0] cfg_seed(input int i); return (i == 0) ? 32'hACE1_2468 : 32'h1; endfunction

  function automatic logic         f_req(input int i);  return (i == 0) ? req_a  : req_b;  endfunction
  function automatic logic         f_gnt(input int i);  return (i == 0) ? gnt_a  : gnt_b;  endfunction
  function automatic logic         f_eoc(input int i);  return (i == 0) ? eoc_a  : eoc_b;  endfunction
  function automatic logic         f_err(input int i);  return (i == 0) ? err_a  : err_b;  endfunction
  function automatic logic [31:0]  f_addr(input int i); return (i == 0) ? addr_a : addr_b; endfunction
  function automatic logic [23:0]  f_resp(input int i); return (i == 0) ? resp_a : resp_b; endfunction
  function automatic logic [127:0] f_chk(input int i);  return (i == 0) ? chk_a : {64'h0, chk_b}; endfunction

  // Polynomial x^32+x^22+x^2+x+1 as a bit-serial Galois register
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    logic [31:0] t;
    t = s >> 1;
    if (s[0]) begin
      t[31] = ~t[31];
      t[21] = ~t[21];
      t[1]  = ~t[1];
      t[0]  = ~t[0];
    end
    return t;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      en[i] = 1'b0; mode[i] = 2'd0; gnt_en[i] = 1'b0; gnt_force[i] = 1'b0;
      rv[i] = 1'b0; rd[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Full campaign with model of addresses, gaps, outstanding and checksum
  task automatic run_traffic(input int i, input logic [1:0] m, input bit det);
    int n, bytes, maxo, k, resp_m, idle, cyc;
    logic [31:0] mask, lf, exp_addr, prev_addr;
    logic [127:0] chk_m, d;
    logic [1:0] last_gap;
    bit done, prev_wait;
    int pend[$];
    n = cfg_n(i); bytes = cfg_bytes(i); maxo = cfg_max(i); mask = cfg_mask(i);
    lf = cfg_seed(i); chk_m = '0; k = 0; resp_m = 0; idle = 0; cyc = 0;
    done = 1'b0; prev_wait = 1'b0; last_gap = 2'd0; prev_addr = '0;
    do_reset();
    mode[i] = m; en[i] = 1'b1; gnt_en[i] = 1'b1;
    while (!done && cyc < 3000) begin
      @(negedge clk);
      if (f_eoc(i)) begin
        done = 1'b1;
        n_cmp++;
        if (k != n || resp_m != n)
          $display("FAIL eoc_early inst%0d mode%0d: accepts %0d responses %0d, required %0d", i, m, k, resp_m, n);
        n_cmp++;
        if (f_resp(i) !== 24'(n))
          $display("FAIL resp_cnt inst%0d mode%0d: got %0d required %0d", i, m, f_resp(i), n);
        n_cmp++;
        if (f_chk(i) !== chk_m)
          $display("FAIL rdata_chk inst%0d mode%0d: got %h required %h", i, m, f_chk(i), chk_m);
        n_cmp++;
        if (f_err(i) !== 1'b0)
          $display("FAIL err_clean inst%0d mode%0d: got %b required 0", i, m, f_err(i));
        n_cmp++;
        if (f_req(i) !== 1'b0)
          $display("FAIL req_done inst%0d mode%0d: got %b required 0", i, m, f_req(i));
        if (k != n || resp_m != n || f_resp(i) !== 24'(n) || f_chk(i) !== chk_m ||
            f_err(i) !== 1'b0 || f_req(i) !== 1'b0)
          n_fail++;
      end else begin
        if (prev_wait) begin
          n_cmp++;
          if (f_req(i) !== 1'b1 || f_addr(i) !== prev_addr) begin
            n_fail++;
            $display("FAIL req_hold inst%0d: req %b addr %h, required 1 addr %h", i, f_req(i), f_addr(i), prev_addr);
          end
        end
        if (f_req(i) && f_gnt(i)) begin
          exp_addr = (m == 2'd1) ? (32'(k * bytes) & mask) : (lf & mask & ~32'(bytes - 1));
          n_cmp++;
          if (f_addr(i) !== exp_addr || k >= n) begin
            n_fail++;
            $display("FAIL addr inst%0d mode%0d #%0d: got %h required %h (of %0d)", i, m, k, f_addr(i), exp_addr, n);
          end
          if (det && m == 2'd2 && k > 0) begin
            n_cmp++;
            if (idle != int'(last_gap)) begin
              n_fail++;
              $display("FAIL gap inst%0d #%0d: got %0d idle cycles required %0d", i, k, idle, last_gap);
            end
          end
          last_gap = lf[1:0];
          lf = lfsr_next(lf);
          k++;
          pend.push_back(cyc);
          idle = 0; prev_wait = 1'b0;
          n_cmp++;
          if (pend.size() > maxo) begin
            n_fail++;
            $display("FAIL outstanding inst%0d: got %0d required <= %0d", i, pend.size(), maxo);
          end
        end else if (f_req(i)) begin
          prev_wait = 1'b1; prev_addr = f_addr(i);
        end else begin
          prev_wait = 1'b0; idle++;
        end
        @(posedge clk); #1;
        cyc++;
        mode[i] = 2'($urandom);
        gnt_en[i] = det ? 1'b1 : ($urandom_range(0, 2) != 0);
        rv[i] = 1'b0;
        if (pend.size() > 0 && (det ? (pend[0] == cyc - 1) : ($urandom_range(0, 2) != 0))) begin
          d = {$urandom, $urandom, $urandom, $urandom};
          if (i == 1) d[127:64] = '0;
          rd[i] = d; rv[i] = 1'b1;
          chk_m ^= d; resp_m++;
          void'(pend.pop_front());
        end
      end
    end
    if (!done) begin
      n_cmp++; n_fail++;
      $display("FAIL eoc_timeout inst%0d mode%0d: eoc 0 after %0d cycles, required 1", i, m, cyc);
    end
    @(posedge clk); #1;
    en[i] = 1'b0; rv[i] = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      n_cmp++; if (f_req(i)  !== 1'b0)  begin n_fail++; $display("FAIL rst_req inst%0d: got %b required 0", i, f_req(i)); end
      n_cmp++; if (f_eoc(i)  !== 1'b0)  begin n_fail++; $display("FAIL rst_eoc inst%0d: got %b required 0", i, f_eoc(i)); end
      n_cmp++; if (f_err(i)  !== 1'b0)  begin n_fail++; $display("FAIL rst_err inst%0d: got %b required 0", i, f_err(i)); end
      n_cmp++; if (f_chk(i)  !== '0)    begin n_fail++; $display("FAIL rst_chk inst%0d: got %h required 0", i, f_chk(i)); end
      n_cmp++; if (f_resp(i) !== 24'd0) begin n_fail++; $display("FAIL rst_resp inst%0d: got %0d required 0", i, f_resp(i)); end
    end
  endtask

  task automatic test_seq_basic(); run_traffic(0, 2'd1, 1'b1); endtask
  task automatic test_seq_wrap();  run_traffic(1, 2'd1, 1'b1); endtask
  task automatic test_gap_mode();  run_traffic(1, 2'd2, 1'b1); endtask

  task automatic test_random_traffic();
    for (int r = 0; r < 8; r++) run_traffic(r % 2, 2'($urandom), 1'b0);
  endtask

  task automatic test_outstanding();
    int acc;
    do_reset();
    mode[1] = 2'd0; en[1] = 1'b1; gnt_en[1] = 1'b1;
    acc = 0;
    repeat (12) begin
      @(negedge clk);
      if (req_b && gnt_b) acc++;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (acc != 2) begin n_fail++; $display("FAIL max_outs_accepts: got %0d required 2", acc); end
    @(negedge clk);
    n_cmp++;
    if (req_b !== 1'b0) begin n_fail++; $display("FAIL max_outs_req_low: got %b required 0", req_b); end
    @(posedge clk); #1;
    rv[1] = 1'b1; rd[1] = 128'h5A;
    @(posedge clk); #1;
    rv[1] = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (req_b !== 1'b1) begin n_fail++; $display("FAIL max_outs_resume: got %b required 1", req_b); end
  endtask

  task automatic test_stall();
    int w;
    logic [31:0] held;
    do_reset();
    mode[0] = 2'd1; en[0] = 1'b1; gnt_en[0] = 1'b0;
    w = 0;
    @(negedge clk);
    while (req_a !== 1'b1 && w < 5) begin
      @(posedge clk); #1; @(negedge clk); w++;
    end
    held = addr_a;
    n_cmp++;
    if (req_a !== 1'b1 || held !== 32'h0) begin
      n_fail++; $display("FAIL stall_first: req %b addr %h, required 1 addr 0", req_a, held);
    end
    for (int j = 0; j < 5; j++) begin
      @(posedge clk); #1;
      if (j == 1) begin en[0] = 1'b0; mode[0] = 2'd2; end
      @(negedge clk);
      n_cmp++;
      if (req_a !== 1'b1 || addr_a !== held) begin
        n_fail++; $display("FAIL stall_hold cyc%0d: req %b addr %h, required 1 addr %h", j, req_a, addr_a, held);
      end
    end
    @(posedge clk); #1 gnt_en[0] = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (gnt_a !== 1'b1 || addr_a !== held) begin
      n_fail++; $display("FAIL stall_accept: gnt %b addr %h, required 1 addr %h", gnt_a, addr_a, held);
    end
    @(posedge clk); #1 gnt_en[0] = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (req_a !== 1'b0) begin n_fail++; $display("FAIL stall_disabled: req %b required 0", req_a); end
  endtask

  task automatic test_error();
    do_reset();
    rv[0] = 1'b1; rd[0] = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    n_cmp++;
    if (err_a !== 1'b0) begin n_fail++; $display("FAIL err_latency: got %b required 0", err_a); end
    @(posedge clk); #1 rv[0] = 1'b0;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      n_cmp++;
      if (err_a !== 1'b1) begin n_fail++; $display("FAIL err_sticky cyc%0d: got %b required 1", j, err_a); end
      @(posedge clk); #1;
    end
    en[0] = 1'b1; mode[0] = 2'd1;
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if (req_a !== 1'b1 || addr_a !== 32'h0) begin
      n_fail++; $display("FAIL err_no_underflow: req %b addr %h, required 1 addr 0", req_a, addr_a);
    end
    do_reset();
    gnt_force[1] = 1'b1;
    @(posedge clk); #1 gnt_force[1] = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (err_b !== 1'b1) begin n_fail++; $display("FAIL err_gnt_no_req: got %b required 1", err_b); end
  endtask

  task automatic test_midrun_reset();
    int acc;
    do_reset();
    mode[0] = 2'd1; en[0] = 1'b1; gnt_en[0] = 1'b1;
    acc = 0;
    for (int j = 0; j < 10 && acc < 2; j++) begin
      @(negedge clk);
      if (req_a && gnt_a) acc++;
      if (acc < 2) begin @(posedge clk); #1; end
    end
    n_cmp++;
    if (acc != 2) begin n_fail++; $display("FAIL midrun_accepts: got %0d required 2", acc); end
    @(posedge clk); #1;
    rst = 1'b1; en[0] = 1'b0; gnt_en[0] = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (req_a !== 1'b0 || resp_a !== 24'd0 || err_a !== 1'b0) begin
      n_fail++; $display("FAIL midrun_reset: req %b resp %0d err %b, required 0 0 0", req_a, resp_a, err_a);
    end
    @(posedge clk); #1 rv[0] = 1'b1;
    @(posedge clk); #1 rv[0] = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (err_a !== 1'b1) begin n_fail++; $display("FAIL midrun_late_resp: err %b required 1", err_a); end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_seq_basic();
    test_seq_wrap();
    test_outstanding();
    test_stall();
    test_error();
    test_gap_mode();
    test_midrun_reset();
    test_random_traffic();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
